// File: rtl/wb_commit_pkg.sv
// Shared constants and commit-record type for the writeback/commit stage.
// Imported by mem_stage_if users, cmt_fifo and wb_commit.
package wb_commit_pkg;

  localparam logic [31:0] ADDR_INVALID     = 32'h0000_0000;
  localparam logic [31:0] DATA_INVALID     = 32'h0000_0000;
  localparam logic [4:0]  REG_ADDR_INVALID = 5'd0;
  localparam logic        EN_INVALID       = 1'b0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } cmt_rec_t;

  // x0 is hardwired to zero, so a write to it is never architecturally visible.
  function automatic logic rf_write_en(input logic rw_en, input logic [4:0] rw_addr);
    return rw_en && (rw_addr != 5'd0);
  endfunction

endpackage

// File: rtl/wb_commit_if.sv
// MEM_WB stage payload bundle handed from the memory stage to writeback.
// The 'i' modport is the consumer view used by wb_commit.
interface mem_stage_if;
  logic [31:0] pc;
  logic [31:0] inst;
  logic [31:0] rw_data;
  logic [4:0]  rw_addr;
  logic        rw_en;

  modport master (output pc, output inst, output rw_data, output rw_addr, output rw_en);
  modport slave  (input pc, input inst, input rw_data, input rw_addr, input rw_en);
  modport i      (input pc, input inst, input rw_data, input rw_addr, input rw_en);
endinterface

// File: rtl/wb_commit_cmt_fifo.sv
// Commit-record FIFO with valid/ready on both sides; occupancy counter decides full/empty.
// No pass-through: a full FIFO refuses input even while it is being drained.
module cmt_fifo
  import wb_commit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     in_valid,
  output logic     in_ready,
  input  cmt_rec_t in_data,
  output logic     out_valid,
  input  logic     out_ready,
  output cmt_rec_t out_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  cmt_rec_t mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_en;
  logic             rd_en;

  always_comb begin
    in_ready  = (count_q != FULL_CNT);
    out_valid = (count_q != '0);
    out_data  = mem_q[rd_ptr_q];
    wr_en     = in_valid && in_ready;
    rd_en     = out_valid && out_ready;
    // Power-of-two depth lets the pointers wrap by plain overflow.
    wr_ptr_d  = wr_ptr_q + PTR_W'(wr_en);
    rd_ptr_d  = rd_ptr_q + PTR_W'(rd_en);
    count_d   = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: rtl/wb_commit.sv
// Writeback stage: regfile write, in-order commit-record buffer and instret counter.
// Define WB_BYPASS_EN to expose the same-cycle forwarding port (fwd_*).
module wb_commit
  import wb_commit_pkg::*;
#(
  parameter int CMT_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ls_valid,
  output logic        ts_ready,
  input  logic        stall,
  input  logic        flush,
  mem_stage_if.i      wb_info,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        cmt_valid,
  input  logic        cmt_ready,
  output logic [31:0] cmt_pc,
  output logic [31:0] cmt_inst,
  output logic        cmt_wen,
  output logic [4:0]  cmt_waddr,
  output logic [31:0] cmt_wdata,
  output logic [63:0] instret
`ifdef WB_BYPASS_EN
  ,
  output logic        fwd_valid,
  output logic [4:0]  fwd_addr,
  output logic [31:0] fwd_data
`endif
);

  logic        fifo_in_ready;
  logic        head_valid;
  cmt_rec_t    head_rec;
  cmt_rec_t    enq_rec;
  logic        accept;
  logic        wen;
  logic [63:0] instret_q, instret_d;

  always_comb begin
    wen      = rf_write_en(wb_info.rw_en, wb_info.rw_addr);
    // Readiness ignores cmt_ready so a full buffer never passes a record straight through.
    ts_ready = !rst && !stall && fifo_in_ready;
    accept   = ls_valid && ts_ready && !flush;

    rf_we    = EN_INVALID;
    rf_waddr = REG_ADDR_INVALID;
    rf_wdata = DATA_INVALID;
    if (accept) begin
      rf_we    = wen;
      rf_waddr = wb_info.rw_addr;
      rf_wdata = wb_info.rw_data;
    end

    enq_rec = '{pc: wb_info.pc, inst: wb_info.inst, wen: wen,
                waddr: wb_info.rw_addr, wdata: wb_info.rw_data};

    instret_d = instret_q + 64'(accept);

    cmt_valid = head_valid;
    cmt_pc    = ADDR_INVALID;
    cmt_inst  = DATA_INVALID;
    cmt_wen   = EN_INVALID;
    cmt_waddr = REG_ADDR_INVALID;
    cmt_wdata = DATA_INVALID;
    if (head_valid) begin
      cmt_pc    = head_rec.pc;
      cmt_inst  = head_rec.inst;
      cmt_wen   = head_rec.wen;
      cmt_waddr = head_rec.waddr;
      cmt_wdata = head_rec.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign instret = instret_q;

  cmt_fifo #(
    .DEPTH (CMT_DEPTH)
  ) u_cmt_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (accept),
    .in_ready  (fifo_in_ready),
    .in_data   (enq_rec),
    .out_valid (head_valid),
    .out_ready (cmt_ready),
    .out_data  (head_rec)
  );

`ifdef WB_BYPASS_EN
  assign fwd_valid = rf_we;
  assign fwd_addr  = rf_waddr;
  assign fwd_data  = rf_wdata;
`endif

endmodule

// File: tb/tb_wb_commit.sv
// Self-checking bench for wb_commit: directed scenarios plus randomized traffic
// checked against a queue-based model of the commit stage.
module tb_wb_commit;
  import wb_commit_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ls_valid;
  logic        stall;
  logic        flush;
  logic        cmt_ready;
  logic        ts_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        cmt_valid;
  logic [31:0] cmt_pc;
  logic [31:0] cmt_inst;
  logic        cmt_wen;
  logic [4:0]  cmt_waddr;
  logic [31:0] cmt_wdata;
  logic [63:0] instret;
`ifdef WB_BYPASS_EN
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;
`endif

  mem_stage_if wb_info ();

  always #5 clk = ~clk;

  wb_commit #(.CMT_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .ls_valid  (ls_valid),
    .ts_ready  (ts_ready),
    .stall     (stall),
    .flush     (flush),
    .wb_info   (wb_info),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .cmt_valid (cmt_valid),
    .cmt_ready (cmt_ready),
    .cmt_pc    (cmt_pc),
    .cmt_inst  (cmt_inst),
    .cmt_wen   (cmt_wen),
    .cmt_waddr (cmt_waddr),
    .cmt_wdata (cmt_wdata),
    .instret   (instret)
`ifdef WB_BYPASS_EN
    ,
    .fwd_valid (fwd_valid),
    .fwd_addr  (fwd_addr),
    .fwd_data  (fwd_data)
`endif
  );

  // Reference model: records in commit order plus a retired count.
  cmt_rec_t    q[$];
  logic [63:0] m_instret = '0;
  int          checks    = 0;
  int          failures  = 0;

  // Called at a negedge: sets inputs, then lets combinational outputs settle.
  task automatic drive(input bit r, input bit v, input bit s, input bit f, input bit cr,
                       input logic [4:0] addr, input bit en,
                       input logic [31:0] pc, input logic [31:0] data);
    rst             = r;
    ls_valid        = v;
    stall           = s;
    flush           = f;
    cmt_ready       = cr;
    wb_info.rw_addr = addr;
    wb_info.rw_en   = en;
    wb_info.pc      = pc;
    wb_info.rw_data = data;
    wb_info.inst    = $urandom;
    #1;
  endtask

  // Advances one clock, applying the spec rules to the model, and returns at the next negedge.
  task automatic tick();
    bit       acc;
    bit       deq;
    cmt_rec_t rec;
    acc = !rst && ls_valid && !stall && !flush && (q.size() < DEPTH);
    deq = !rst && (q.size() > 0) && cmt_ready;
    rec.pc    = wb_info.pc;
    rec.inst  = wb_info.inst;
    rec.wen   = wb_info.rw_en && (wb_info.rw_addr != 5'd0);
    rec.waddr = wb_info.rw_addr;
    rec.wdata = wb_info.rw_data;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_instret = '0;
      $display("txn reset");
    end else begin
      if (deq) begin
        $display("txn commit pc=%h wdata=%h", q[0].pc, q[0].wdata);
        void'(q.pop_front());
      end
      if (acc) begin
        q.push_back(rec);
        m_instret = m_instret + 64'd1;
        $display("txn accept pc=%h wen=%0b waddr=%0d wdata=%h", rec.pc, rec.wen, rec.waddr, rec.wdata);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1, 1, 0, 0, 1, 5'd3, 1, 32'h0000_1000, 32'h1234_5678);
    if (ts_ready !== 1'b0) begin failures++; $display("FAIL reset_ts_ready got=%0b exp=0", ts_ready); end
    checks++;
    if (rf_we !== 1'b0) begin failures++; $display("FAIL reset_rf_we got=%0b exp=0", rf_we); end
    checks++;
    tick();
    drive(0, 0, 0, 0, 0, 5'd0, 0, 32'h0, 32'h0);
    if (cmt_valid !== 1'b0) begin failures++; $display("FAIL reset_cmt_valid got=%0b exp=0", cmt_valid); end
    checks++;
    if (instret !== 64'd0) begin failures++; $display("FAIL reset_instret got=%0d exp=0", instret); end
    checks++;
    if (ts_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ts_ready got=%0b exp=1", ts_ready); end
    checks++;
  endtask

  task automatic test_basic();
    drive(0, 1, 0, 0, 0, 5'd5, 1, 32'h1C00_0000, 32'hDEAD_BEEF);
    if (rf_we !== 1'b1) begin failures++; $display("FAIL basic_rf_we got=%0b exp=1", rf_we); end
    checks++;
    if (rf_waddr !== 5'd5 || rf_wdata !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL basic_rf_port got=%0d/%h exp=5/deadbeef", rf_waddr, rf_wdata);
    end
    checks++;
    if (cmt_valid !== 1'b0) begin failures++; $display("FAIL basic_cmt_early got=%0b exp=0", cmt_valid); end
    checks++;
    tick();
    drive(0, 0, 0, 0, 0, 5'd0, 0, 32'h0, 32'h0);
    if (cmt_valid !== 1'b1 || cmt_pc !== 32'h1C00_0000 || cmt_wdata !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL basic_cmt_rec got=%0b/%h/%h exp=1/1c000000/deadbeef", cmt_valid, cmt_pc, cmt_wdata);
    end
    checks++;
    if (cmt_wen !== 1'b1 || cmt_waddr !== 5'd5) begin
      failures++; $display("FAIL basic_cmt_wen got=%0b/%0d exp=1/5", cmt_wen, cmt_waddr);
    end
    checks++;
    if (instret !== 64'd1) begin failures++; $display("FAIL basic_instret got=%0d exp=1", instret); end
    checks++;
    drive(0, 0, 0, 0, 1, 5'd0, 0, 32'h0, 32'h0);
    tick();
    drive(0, 0, 0, 0, 0, 5'd0, 0, 32'h0, 32'h0);
    if (cmt_valid !== 1'b0) begin failures++; $display("FAIL basic_drain got=%0b exp=0", cmt_valid); end
    checks++;
  endtask

  task automatic test_zero_addr();
    logic [63:0] base;
    base = m_instret;
    drive(0, 1, 0, 0, 0, 5'd0, 1, 32'h1C00_0004, $urandom);
    if (rf_we !== 1'b0) begin failures++; $display("FAIL x0_rf_we got=%0b exp=0", rf_we); end
    checks++;
    tick();
    drive(0, 0, 0, 0, 0, 5'd0, 0, 32'h0, 32'h0);
    if (cmt_valid !== 1'b1 || cmt_wen !== 1'b0 || cmt_pc !== 32'h1C00_0004) begin
      failures++; $display("FAIL x0_cmt_rec got=%0b/%0b/%h exp=1/0/1c000004", cmt_valid, cmt_wen, cmt_pc);
    end
    checks++;
    if (instret !== base + 64'd1) begin failures++; $display("FAIL x0_instret got=%0d exp=%0d", instret, base + 64'd1); end
    checks++;
    drive(0, 0, 0, 0, 1, 5'd0, 0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_full();
    logic [31:0] pcs[5];
    logic [63:0] base;
    bit          exp;
    base = m_instret;
    for (int i = 0; i < 5; i++) pcs[i] = 32'h1C00_1000 + 32'(i * 4);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 0, 0, 5'(i + 1), 1, pcs[i], $urandom);
      exp = (i < DEPTH);
      if (ts_ready !== exp) begin failures++; $display("FAIL full_ts_ready[%0d] got=%0b exp=%0b", i, ts_ready, exp); end
      checks++;
      tick();
    end
    drive(0, 1, 0, 0, 1, 5'd5, 1, pcs[4], 32'h5555_0005);
    if (ts_ready !== 1'b0) begin failures++; $display("FAIL full_no_passthru got=%0b exp=0", ts_ready); end
    checks++;
    if (cmt_pc !== pcs[0]) begin failures++; $display("FAIL full_head0 got=%h exp=%h", cmt_pc, pcs[0]); end
    checks++;
    tick();
    drive(0, 1, 0, 0, 0, 5'd5, 1, pcs[4], 32'h5555_0005);
    if (ts_ready !== 1'b1) begin failures++; $display("FAIL full_reopen got=%0b exp=1", ts_ready); end
    checks++;
    tick();
    for (int i = 1; i < 5; i++) begin
      drive(0, 0, 0, 0, 1, 5'd0, 0, 32'h0, 32'h0);
      if (cmt_valid !== 1'b1 || cmt_pc !== pcs[i]) begin
        failures++; $display("FAIL full_order[%0d] got=%0b/%h exp=1/%h", i, cmt_valid, cmt_pc, pcs[i]);
      end
      checks++;
      tick();
    end
    drive(0, 0, 0, 0, 0, 5'd0, 0, 32'h0, 32'h0);
    if (cmt_valid !== 1'b0) begin failures++; $display("FAIL full_empty got=%0b exp=0", cmt_valid); end
    checks++;
    if (instret !== base + 64'd5) begin failures++; $display("FAIL full_instret got=%0d exp=%0d", instret, base + 64'd5); end
    checks++;
  endtask

  task automatic test_flush();
    logic [63:0] base;
    base = m_instret;
    drive(0, 1, 0, 0, 0, 5'd9, 1, 32'h1C00_2000, $urandom);
    tick();
    drive(0, 1, 0, 0, 0, 5'd10, 1, 32'h1C00_2004, $urandom);
    tick();
    drive(0, 1, 0, 1, 0, 5'd11, 1, 32'h1C00_2008, $urandom);
    if (rf_we !== 1'b0) begin failures++; $display("FAIL flush_rf_we got=%0b exp=0", rf_we); end
    checks++;
    tick();
    drive(0, 0, 0, 0, 0, 5'd0, 0, 32'h0, 32'h0);
    if (instret !== base + 64'd2) begin failures++; $display("FAIL flush_instret got=%0d exp=%0d", instret, base + 64'd2); end
    checks++;
    drive(0, 0, 0, 0, 1, 5'd0, 0, 32'h0, 32'h0);
    if (cmt_valid !== 1'b1 || cmt_pc !== 32'h1C00_2000) begin
      failures++; $display("FAIL flush_keep0 got=%0b/%h exp=1/1c002000", cmt_valid, cmt_pc);
    end
    checks++;
    tick();
    drive(0, 0, 0, 0, 1, 5'd0, 0, 32'h0, 32'h0);
    if (cmt_valid !== 1'b1 || cmt_pc !== 32'h1C00_2004) begin
      failures++; $display("FAIL flush_keep1 got=%0b/%h exp=1/1c002004", cmt_valid, cmt_pc);
    end
    checks++;
    tick();
    drive(0, 0, 0, 0, 0, 5'd0, 0, 32'h0, 32'h0);
    if (cmt_valid !== 1'b0) begin failures++; $display("FAIL flush_empty got=%0b exp=0", cmt_valid); end
    checks++;
  endtask

  task automatic test_stall();
    logic [63:0] base;
    logic [31:0] data;
    base = m_instret;
    data = $urandom;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 0, 0, 5'd7, 1, 32'h1C00_3000, data);
      if (rf_we !== 1'b0 || ts_ready !== 1'b0) begin
        failures++; $display("FAIL stall_blocked[%0d] got=%0b/%0b exp=0/0", i, rf_we, ts_ready);
      end
      checks++;
      tick();
    end
    if (instret !== base) begin failures++; $display("FAIL stall_instret got=%0d exp=%0d", instret, base); end
    checks++;
    drive(0, 1, 0, 0, 0, 5'd7, 1, 32'h1C00_3000, data);
    if (rf_we !== 1'b1 || rf_wdata !== data) begin
      failures++; $display("FAIL stall_release got=%0b/%h exp=1/%h", rf_we, rf_wdata, data);
    end
    checks++;
    tick();
    drive(0, 0, 0, 0, 1, 5'd0, 0, 32'h0, 32'h0);
    if (instret !== base + 64'd1) begin failures++; $display("FAIL stall_single got=%0d exp=%0d", instret, base + 64'd1); end
    checks++;
    tick();
    drive(0, 0, 0, 0, 0, 5'd0, 0, 32'h0, 32'h0);
    if (cmt_valid !== 1'b0) begin failures++; $display("FAIL stall_one_rec got=%0b exp=0", cmt_valid); end
    checks++;
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 0, 0, 0, 5'd0, 0, 32'h0, 32'h0);
    tick();
    for (int i = 0; i < 7; i++) begin
      drive(0, 1, 0, 0, (i < 5), 5'(i + 1), 1, 32'h1C00_4000 + 32'(i * 4), $urandom);
      tick();
    end
    drive(0, 0, 0, 0, 0, 5'd0, 0, 32'h0, 32'h0);
    if (instret !== 64'd7 || cmt_valid !== 1'b1) begin
      failures++; $display("FAIL rstmid_setup got=%0d/%0b exp=7/1", instret, cmt_valid);
    end
    checks++;
    drive(1, 1, 1, 1, 1, 5'd3, 1, 32'h1C00_4100, $urandom);
    if (rf_we !== 1'b0 || ts_ready !== 1'b0) begin
      failures++; $display("FAIL rstmid_hold got=%0b/%0b exp=0/0", rf_we, ts_ready);
    end
    checks++;
    tick();
    drive(0, 0, 0, 0, 0, 5'd0, 0, 32'h0, 32'h0);
    if (cmt_valid !== 1'b0 || instret !== 64'd0) begin
      failures++; $display("FAIL rstmid_clear got=%0b/%0d exp=0/0", cmt_valid, instret);
    end
    checks++;
    tick();
    if (cmt_valid !== 1'b0) begin failures++; $display("FAIL rstmid_dropped got=%0b exp=0", cmt_valid); end
    checks++;
  endtask

  task automatic test_random();
    bit       r, v, s, f, cr, en;
    bit       exp_ts, exp_acc, exp_we;
    logic [4:0] addr;
    cmt_rec_t got;
    for (int n = 0; n < 400; n++) begin
      r    = ($urandom_range(0, 49) == 0);
      v    = ($urandom_range(0, 3) != 0);
      s    = ($urandom_range(0, 4) == 0);
      f    = ($urandom_range(0, 7) == 0);
      cr   = ($urandom_range(0, 1) == 0);
      en   = ($urandom_range(0, 3) != 0);
      addr = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      drive(r, v, s, f, cr, addr, en, $urandom, $urandom);
      exp_ts  = !r && !s && (q.size() < DEPTH);
      exp_acc = exp_ts && v && !f;
      exp_we  = exp_acc && en && (addr != 5'd0);
      if (ts_ready !== exp_ts) begin failures++; $display("FAIL rnd_ts_ready[%0d] got=%0b exp=%0b", n, ts_ready, exp_ts); end
      checks++;
      if (rf_we !== exp_we) begin failures++; $display("FAIL rnd_rf_we[%0d] got=%0b exp=%0b", n, rf_we, exp_we); end
      checks++;
      if (exp_we && (rf_waddr !== addr || rf_wdata !== wb_info.rw_data)) begin
        failures++; $display("FAIL rnd_rf_port[%0d] got=%0d/%h exp=%0d/%h", n, rf_waddr, rf_wdata, addr, wb_info.rw_data);
      end
      checks++;
`ifdef WB_BYPASS_EN
      if (fwd_valid !== exp_we) begin failures++; $display("FAIL rnd_fwd_valid[%0d] got=%0b exp=%0b", n, fwd_valid, exp_we); end
      checks++;
`endif
      if (cmt_valid !== (q.size() > 0)) begin
        failures++; $display("FAIL rnd_cmt_valid[%0d] got=%0b exp=%0b", n, cmt_valid, (q.size() > 0));
      end
      checks++;
      if (q.size() > 0) begin
        got = '{pc: cmt_pc, inst: cmt_inst, wen: cmt_wen, waddr: cmt_waddr, wdata: cmt_wdata};
        if (got !== q[0]) begin failures++; $display("FAIL rnd_cmt_rec[%0d] got=%h exp=%h", n, got, q[0]); end
        checks++;
      end
      if (instret !== m_instret) begin failures++; $display("FAIL rnd_instret[%0d] got=%0d exp=%0d", n, instret, m_instret); end
      checks++;
      tick();
    end
  endtask

  initial begin
    rst             = 1'b1;
    ls_valid        = 1'b0;
    stall           = 1'b0;
    flush           = 1'b0;
    cmt_ready       = 1'b0;
    wb_info.pc      = '0;
    wb_info.inst    = '0;
    wb_info.rw_data = '0;
    wb_info.rw_addr = '0;
    wb_info.rw_en   = 1'b0;
    @(negedge clk);
    tick();
    test_reset();
    test_basic();
    test_zero_addr();
    test_full();
    test_flush();
    test_stall();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_commit.md
WB_COMMIT -- requirements
Module: wb_commit

Interface
REQ-001 SHALL have parameter: CMT_DEPTH, 4, commit-buffer entries (power of 2, >=2).
REQ-002 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: ls_valid  input  1  MEM_WB stage holds a valid instruction.
REQ-005 SHALL have port: ts_ready  output  1  writeback can accept this cycle.
REQ-006 SHALL have port: stall  input  1  global pipeline stall.
REQ-007 SHALL have port: flush  input  1  global pipeline flush.
REQ-008 SHALL have port: wb_info  mem_stage_if.i  --  pc[31:0], inst[31:0], rw_data[31:0], rw_addr[4:0], rw_en.
REQ-009 SHALL have port: rf_we / rf_waddr / rf_wdata  output  1/5/32  regfile write port.
REQ-010 SHALL have port: cmt_valid  output  1  commit record available.
REQ-011 SHALL have port: cmt_ready  input  1  trace consumer accepts record.
REQ-012 SHALL have port: cmt_pc / cmt_inst / cmt_wen / cmt_waddr / cmt_wdata  output  32/32/1/5/32  head commit record.
REQ-013 SHALL have port: instret  output  64  retired-instruction count.
REQ-014 SHALL have port (WB_BYPASS_EN only): fwd_valid / fwd_addr / fwd_data  output  1/5/32  same-cycle forwarding.

Function
REQ-015 SHALL define accept = ls_valid & ts_ready & !flush; ts_ready = !stall & !full (combinational, independent of cmt_ready).
REQ-016 SHALL, in an accept cycle, drive rf_we = rw_en & (rw_addr != 0), rf_waddr = rw_addr, rf_wdata = rw_data combinationally; rf_we=0 otherwise.
REQ-017 SHALL, on accept, enqueue {pc, inst, rw_en&(rw_addr!=0), rw_addr, rw_data} at tail; record visible on cmt_* no earlier than next cycle.
REQ-018 SHALL present head entry on cmt_*; cmt_valid = !empty; dequeue when cmt_valid & cmt_ready.
REQ-019 SHALL hold cmt_* stable while cmt_valid & !cmt_ready.
REQ-020 SHALL support simultaneous enqueue and dequeue; count unchanged, both pointers advance.
REQ-021 SHALL, when full, deassert ts_ready even if cmt_ready=1 that cycle (no same-cycle pass-through).
REQ-022 SHALL wrap pointers modulo CMT_DEPTH; full/empty by occupancy counter of width log2(CMT_DEPTH)+1.
REQ-023 SHALL increment instret by 1 per accept, wrapping at 2^64; no change otherwise.
REQ-024 SHALL NOT discard buffered entries on flush; flush only blocks accept in that cycle.
REQ-025 SHALL NOT accept, write regfile, or count when stall=1, regardless of ls_valid.

Reset
REQ-026 SHALL, when rst=1 at clk edge, clear pointers/count (cmt_valid=0), instret=0; rf_we=0 and ts_ready=0 while rst=1.
REQ-027 SHALL drop buffered entries on reset mid-operation; rst dominates flush, stall, cmt_ready.

Configuration
REQ-028 SHALL, with WB_BYPASS_EN defined, drive fwd_valid=rf_we, fwd_addr=rf_waddr, fwd_data=rf_wdata.
REQ-029 SHALL, without WB_BYPASS_EN, omit fwd_* ports; all other behaviour identical.

Structure
REQ-030 SHALL take ADDR_INVALID, DATA_INVALID, REG_ADDR_INVALID, EN_INVALID from the shared constant include; commit-record typedef (cmt_rec_t) SHALL live in the shared package.
REQ-031 SHALL implement the buffer as one sub-module, cmt_fifo (parameterised depth, valid/ready both sides).

Verification
REQ-032 SHALL cover: ls_valid=1, rw_en=1, rw_addr=5, rw_data=0xDEADBEEF, pc=0x1C000000 -> rf_we=1 same cycle; next cycle cmt_valid=1, cmt_pc=0x1C000000, cmt_wdata=0xDEADBEEF; instret=1.
REQ-033 SHALL cover: rw_en=1, rw_addr=0 -> rf_we=0, record cmt_wen=0, instret increments.
REQ-034 SHALL cover: cmt_ready=0, 5 back-to-back valids (CMT_DEPTH=4) -> 4 accepted, ts_ready=0 at 5th; cmt_ready=1 one cycle -> ts_ready=1 next cycle, records emerge in order.
REQ-035 SHALL cover: flush=1 with ls_valid=1 and 2 entries buffered -> no accept, instret unchanged, both entries later drain.
REQ-036 SHALL cover: stall=1 for 3 cycles with ls_valid=1 -> rf_we=0, instret unchanged; stall=0 -> single accept.
REQ-037 SHALL cover: rst=1 with 3 entries buffered, instret=7 -> next cycle cmt_valid=0, instret=0.
